// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory and decode handshake signals of the fetch unit.
// master: fetch unit side; slave: memory/decode side.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:2] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch FSM with exception redirect,
// including abort/drain of an in-flight memory request.
module pc_fetch_unit #(
  parameter logic [31:2] RESET_PC   = 30'h00000C00,
  parameter logic [31:2] EXC_VECTOR = 30'h00001060
) (
  input  logic                    clk,
  input  logic                    rst,
  pc_fetch_unit_if.master         bus,
  input  logic [31:2]             pc_in,
  input  logic                    exc_req,
  output logic [31:2]             pc_out,
  output logic [31:2]             pc_plus1,
  output logic [31:2]             epc_out
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, DRAIN} state_t;

  state_t      state, state_n;
  logic [31:2] pc, pc_n;
  logic [31:2] epc, epc_n;
  logic [31:2] abort_addr, abort_addr_n;
  logic [31:0] instr_q, instr_n;
  logic        valid_q, valid_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      epc        <= '0;
      abort_addr <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      epc        <= epc_n;
      abort_addr <= abort_addr_n;
      instr_q    <= instr_n;
      valid_q    <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    epc_n        = epc;
    abort_addr_n = abort_addr;
    instr_n      = instr_q;
    valid_n      = valid_q;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        if (exc_req) begin
          epc_n = pc;
          pc_n  = EXC_VECTOR;
        end
      end
      FETCH: begin
        if (exc_req) begin
          epc_n = pc;
          pc_n  = EXC_VECTOR;
          // A request still outstanding must be drained at its original address.
          if (bus.imem_ack) begin
            state_n = FETCH;
          end else begin
            abort_addr_n = pc;
            state_n      = DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_n = bus.imem_rdata;
          valid_n = 1'b1;
          state_n = VALID;
        end
      end
      VALID: begin
        if (exc_req) begin
          epc_n   = pc;
          pc_n    = EXC_VECTOR;
          valid_n = 1'b0;
          state_n = FETCH;
        end else if (bus.instr_ready) begin
          pc_n    = pc_in;
          valid_n = 1'b0;
          state_n = FETCH;
        end
      end
      DRAIN: begin
        if (exc_req) begin
          pc_n = EXC_VECTOR;
        end else if (bus.imem_ack) begin
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_req    = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr   = (state == DRAIN) ? abort_addr : pc;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign pc_out          = pc;
  assign pc_plus1        = pc + 30'd1;
  assign epc_out         = epc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed test of pc_fetch_unit: sequential fetch, memory latency, stall,
// exceptions in VALID/FETCH/DRAIN, mid-fetch reset and PC wrap.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] pc_in;
  logic        exc_req;
  logic [31:2] pc_out;
  logic [31:2] pc_plus1;
  logic [31:2] epc_out;
  logic        pc_follow;
  logic [31:2] pc_fixed;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC  (30'h00000C00),
    .EXC_VECTOR(30'h00001060)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pc_in   (pc_in),
    .exc_req (exc_req),
    .pc_out  (pc_out),
    .pc_plus1(pc_plus1),
    .epc_out (epc_out)
  );

  always #5 clk = ~clk;

  assign pc_in = pc_follow ? pc_plus1 : pc_fixed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    exc_req         = 1'b0;
    pc_follow       = 1'b1;
    pc_fixed        = 30'h0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b1;

    // Reset state
    tick();
    check("rst_req",   {31'b0, bus.imem_req},    32'h0);
    check("rst_pc",    {2'b0, pc_out},           32'hC00);
    check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rst_instr", bus.instr,                32'h0);
    check("rst_epc",   {2'b0, epc_out},          32'h0);
    rst = 1'b0;
    tick();  // IDLE -> FETCH
    check("idle_to_fetch", {31'b0, bus.imem_req}, 32'h1);

    // Zero-wait memory, decode always ready: 2 cycles per instruction
    for (int unsigned i = 0; i < 3; i++) begin
      check("zw_req",  {31'b0, bus.imem_req}, 32'h1);
      check("zw_addr", {2'b0, bus.imem_addr}, 32'hC00 + i);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hA000_0000 + i;
      tick();
      bus.imem_ack = 1'b0;
      check("zw_valid", {31'b0, bus.instr_valid}, 32'h1);
      check("zw_instr", bus.instr,                32'hA000_0000 + i);
      check("zw_req_lo", {31'b0, bus.imem_req},   32'h0);
      tick();
    end

    // 3-cycle ack latency
    bus.instr_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      check("lat_req",   {31'b0, bus.imem_req},    32'h1);
      check("lat_addr",  {2'b0, bus.imem_addr},    32'hC03);
      check("lat_noval", {31'b0, bus.instr_valid}, 32'h0);
      if (i == 2) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2402000A;
      end
      tick();
    end
    bus.imem_ack = 1'b0;
    check("lat_instr", bus.instr,                32'h2402000A);
    check("lat_valid", {31'b0, bus.instr_valid}, 32'h1);

    // Decode stall for 5 cycles
    for (int unsigned i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
      check("stall_instr", bus.instr,                32'h2402000A);
      check("stall_req",   {31'b0, bus.imem_req},    32'h0);
      check("stall_pc",    {2'b0, pc_out},           32'hC03);
      tick();
    end
    pc_follow       = 1'b0;
    pc_fixed        = 30'h1234;
    bus.instr_ready = 1'b1;
    tick();
    check("resume_addr",  {2'b0, bus.imem_addr},    32'h1234);
    check("resume_req",   {31'b0, bus.imem_req},    32'h1);
    check("resume_valid", {31'b0, bus.instr_valid}, 32'h0);

    // Exception in VALID at PC 0xC05 (same-cycle ready ignored)
    pc_fixed     = 30'hC05;
    bus.imem_ack = 1'b1;
    tick();              // VALID @1234
    tick();              // ready -> FETCH @C05
    bus.instr_ready = 1'b0;
    tick();              // ack -> VALID @C05
    bus.imem_ack = 1'b0;
    check("ev_pc", {2'b0, pc_out}, 32'hC05);
    exc_req         = 1'b1;
    bus.instr_ready = 1'b1;
    pc_fixed        = 30'h0777;
    tick();
    exc_req         = 1'b0;
    bus.instr_ready = 1'b0;
    check("ev_epc",   {2'b0, epc_out},          32'hC05);
    check("ev_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("ev_addr",  {2'b0, bus.imem_addr},    32'h1060);
    check("ev_req",   {31'b0, bus.imem_req},    32'h1);

    // Exception in FETCH at PC 0xC08 with delayed ack -> DRAIN
    pc_fixed     = 30'hC08;
    bus.imem_ack = 1'b1;
    tick();              // VALID @1060
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b1;
    tick();              // FETCH @C08
    bus.instr_ready = 1'b0;
    check("ef_addr0", {2'b0, bus.imem_addr}, 32'hC08);
    exc_req = 1'b1;
    tick();              // DRAIN
    exc_req = 1'b0;
    check("dr_req",   {31'b0, bus.imem_req},    32'h1);
    check("dr_addr",  {2'b0, bus.imem_addr},    32'hC08);
    check("dr_pc",    {2'b0, pc_out},           32'h1060);
    check("dr_epc",   {2'b0, epc_out},          32'hC08);
    check("dr_valid", {31'b0, bus.instr_valid}, 32'h0);
    exc_req = 1'b1;      // second exception while draining
    tick();
    exc_req = 1'b0;
    check("dr2_epc",  {2'b0, epc_out},       32'hC08);
    check("dr2_addr", {2'b0, bus.imem_addr}, 32'hC08);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    tick();              // ack discarded -> FETCH @1060
    bus.imem_ack = 1'b0;
    check("dr_done_addr",  {2'b0, bus.imem_addr},    32'h1060);
    check("dr_done_req",   {31'b0, bus.imem_req},    32'h1);
    check("dr_done_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("dr_done_epc",   {2'b0, epc_out},          32'hC08);
    tick();
    check("dr_no_instr",   {31'b0, bus.instr_valid}, 32'h0);

    // Reset during a FETCH wait, stale ack afterwards
    rst = 1'b1;
    #1;
    check("mr_req",   {31'b0, bus.imem_req},    32'h0);
    check("mr_pc",    {2'b0, pc_out},           32'hC00);
    check("mr_valid", {31'b0, bus.instr_valid}, 32'h0);
    tick();
    rst            = 1'b0;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h55555555;
    check("stale_req", {31'b0, bus.imem_req}, 32'h0);
    tick();              // IDLE -> FETCH, stale ack ignored
    bus.imem_ack = 1'b0;
    check("stale_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("stale_instr", bus.instr,                32'h0);
    check("stale_addr",  {2'b0, bus.imem_addr},    32'hC00);

    // PC wrap of pc_plus1
    pc_fixed        = 30'h3FFFFFFF;
    bus.instr_ready = 1'b1;
    bus.imem_ack    = 1'b1;
    tick();              // VALID
    bus.imem_ack = 1'b0;
    tick();              // FETCH @3FFFFFFF
    check("wrap_pc",    {2'b0, pc_out},   32'h3FFFFFFF);
    check("wrap_plus1", {2'b0, pc_plus1}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode with a valid/ready handshake.
- Feeds the current and sequential PC to the next-PC selector, and loads the selector's result when decode accepts an instruction.
- Captures EPC on an exception and redirects to the exception vector, including while a memory request is still in flight.

Parameters:
- RESET_PC, 30'h00000C00, word address loaded at reset (byte 0x00003000).
- EXC_VECTOR, 30'h00001060, word address loaded on an exception (byte 0x00004180).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  [31:2]  next PC word address from the next-PC selector.
- exc_req  in  1  exception request, one-cycle pulse.
- imem_req  out  1  instruction memory request.
- imem_addr  out  [31:2]  instruction memory word address.
- imem_ack  in  1  memory response valid; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr is valid for decode.
- instr_ready  in  1  decode accepts instr.
- pc_out  out  [31:2]  PC of the current fetch or instruction.
- pc_plus1  out  [31:2]  pc_out+1, combinational, wraps modulo 2^30.
- epc_out  out  [31:2]  exception PC register.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, PC=RESET_PC, instr=0, instr_valid=0, epc_out=0.
  - imem_req=0 while rst is high.
- FSM states: IDLE, FETCH, VALID, DRAIN.
- IDLE:
  - imem_req=0.
  - Next cycle goes to FETCH, unless exc_req is high (see Exceptions).
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Request and address stay stable until imem_ack.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go to VALID.
  - Zero-wait memory (ack in the first FETCH cycle) is legal.
- VALID:
  - instr_valid=1, instr held stable, imem_req=0.
  - On instr_ready: PC<=pc_in, instr_valid<=0, go to FETCH.
  - Without instr_ready: hold indefinitely. This is the stall.
- DRAIN:
  - imem_req=1, imem_addr=old PC held in a separate abort-address register.
  - On imem_ack: discard data, go to FETCH at the new PC.
  - instr_valid=0 throughout.
- Exceptions (exc_req=1), highest priority in every state:
  - IDLE: epc<=PC, PC<=EXC_VECTOR, go to FETCH.
  - VALID: epc<=PC, PC<=EXC_VECTOR, instr_valid<=0, go to FETCH. instr_ready in the same cycle is ignored.
  - FETCH with imem_ack the same cycle: epc<=PC, PC<=EXC_VECTOR, response discarded, go to FETCH.
  - FETCH without imem_ack: epc<=PC, abort address<=PC, PC<=EXC_VECTOR, go to DRAIN.
  - DRAIN: epc is not overwritten, PC<=EXC_VECTOR, stay in DRAIN.
- pc_out always equals PC. In DRAIN it already shows EXC_VECTOR.
- Return from exception is not handled here: the next-PC selector supplies epc_out through pc_in.
- Reset asserted mid-operation: immediate return to reset values. Any outstanding memory response is ignored because imem_req and the state are cleared.
- No combinational path from imem_ack or imem_rdata to instr or instr_valid: one-cycle latency from ack to valid.

Test Plan:
- Reset, then zero-wait memory, decode always ready:
  - imem_addr sequence 0xC00, 0xC01, 0xC02 with pc_in=pc_plus1.
  - instr_valid rises 1 cycle after each ack.
  - 2 cycles per instruction.
- Memory with 3-cycle ack latency:
  - imem_req held high 3 cycles with a stable address.
  - instr equals rdata 0x2402000A one cycle after ack.
- Decode stall: instr_ready=0 for 5 cycles in VALID:
  - instr and instr_valid held, imem_req=0, PC unchanged.
  - Fetch resumes at pc_in=0x1234 after ready.
- exc_req in VALID at PC=0xC05:
  - epc_out=0xC05, instr_valid drops next cycle, next imem_addr=0x1060.
- exc_req in FETCH (PC=0xC08) with ack delayed 2 cycles:
  - DRAIN holds req/addr=0xC08 until ack, data discarded.
  - Then fetch at 0x1060, epc_out=0xC08.
  - A second exc_req during DRAIN leaves epc_out=0xC08.
- rst asserted in the middle of a FETCH wait:
  - imem_req=0 immediately, PC=0xC00, instr_valid=0.
  - A stale ack after release has no effect.
